// File: rtl/svi_array_sequencer_if.sv
// svi_array_sequencer_if -- one output channel of the array sequencer.
//   x : constant level (the sequencer's Z parameter)
//   y : "out of reset" flag, 0 during reset, 1 from the first edge after release
//   z : programmable level (CONST / LIT / SIGNAL / PULSE behaviour)
// master: the sequencer (drives x, y, z); slave: any consumer.
interface svi_array_sequencer_if;
  logic x;
  logic y;
  logic z;

  modport master (output x, y, z);
  modport slave  (input  x, y, z);
endinterface

// File: rtl/svi_array_sequencer.sv
// svi_array_sequencer -- accepts channel commands through a valid/ready port
// and programs the z behaviour of an array of NCHAN interface instances.
//
// Ports
//   i_clk, i_rst           : clock, asynchronous active-high reset
//   i_a                    : source level for SIGNAL mode
//   i_cmd_valid/o_cmd_ready: command handshake (one accept every 2 cycles max)
//   i_cmd_chan/mode/len    : target channel, mode (0 CONST,1 LIT,2 SIGNAL,3 PULSE),
//                            pulse length
//   u_I[NCHAN]             : per-channel x/y/z outputs
//   o_a/o_b/o_c            : readback of x/y/z, one bit per channel
//   o_busy                 : channel has a PULSE in progress

// Per-channel state: mode, pulse counter and the registered z level.
// A write from the command FSM takes priority over the channel's own
// time step (pulse expiry / signal sampling) on the same edge.
module svi_array_sequencer_chan #(
  parameter int   WIDTH = 4,
  parameter logic Z     = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a,
  input  logic             i_wr,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_len,
  output logic             o_z,
  output logic             o_busy
);
  localparam logic [1:0] M_CONST  = 2'd0;
  localparam logic [1:0] M_LIT    = 2'd1;
  localparam logic [1:0] M_SIGNAL = 2'd2;
  localparam logic [1:0] M_PULSE  = 2'd3;

  logic [1:0]       mode_q;
  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q <= M_CONST;
      cnt_q  <= '0;
      o_z    <= Z;
    end else if (i_wr) begin
      cnt_q <= '0;
      case (i_mode)
        M_LIT: begin
          mode_q <= M_LIT;
          o_z    <= 1'b1;
        end
        M_SIGNAL: begin
          mode_q <= M_SIGNAL;
          o_z    <= i_a;
        end
        M_PULSE: begin
          // zero-length pulse degenerates to CONST
          if (i_len != '0) begin
            mode_q <= M_PULSE;
            cnt_q  <= i_len;
            o_z    <= 1'b1;
          end else begin
            mode_q <= M_CONST;
            o_z    <= Z;
          end
        end
        default: begin
          mode_q <= M_CONST;
          o_z    <= Z;
        end
      endcase
    end else begin
      case (mode_q)
        M_SIGNAL: o_z <= i_a;
        M_PULSE: begin
          // counter holds the remaining high cycles; the last one reverts to CONST
          if (cnt_q <= WIDTH'(1)) begin
            mode_q <= M_CONST;
            cnt_q  <= '0;
            o_z    <= Z;
          end else begin
            cnt_q <= cnt_q - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = |cnt_q;
endmodule

module svi_array_sequencer #(
  parameter  int   NCHAN = 8,
  parameter  int   WIDTH = 4,
  parameter  logic Z     = 1'b0,
  localparam int   CHW   = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_a,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [CHW-1:0]        i_cmd_chan,
  input  logic [1:0]            i_cmd_mode,
  input  logic [WIDTH-1:0]      i_cmd_len,
  svi_array_sequencer_if.master u_I [NCHAN-1:0],
  output logic [NCHAN-1:0]      o_a,
  output logic [NCHAN-1:0]      o_b,
  output logic [NCHAN-1:0]      o_c,
  output logic [NCHAN-1:0]      o_busy
);
  typedef enum logic {IDLE, APPLY} state_t;

  state_t           state;
  logic [CHW-1:0]   lat_chan;
  logic [1:0]       lat_mode;
  logic [WIDTH-1:0] lat_len;
  logic             y_q;
  logic [NCHAN-1:0] z_q;
  logic             apply_st;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      o_cmd_ready <= 1'b1;
      lat_chan    <= '0;
      lat_mode    <= '0;
      lat_len     <= '0;
      y_q         <= 1'b0;
    end else begin
      y_q <= 1'b1;
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            lat_chan    <= i_cmd_chan;
            lat_mode    <= i_cmd_mode;
            lat_len     <= i_cmd_len;
            state       <= APPLY;
            o_cmd_ready <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          o_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  assign apply_st = (state == APPLY);

  // Out-of-range channel indices simply match no instance below, so the
  // APPLY cycle is spent without touching any channel.
  for (genvar g = 0; g < NCHAN; g++) begin : g_ch
    svi_array_sequencer_chan #(
      .WIDTH (WIDTH),
      .Z     (Z)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_a    (i_a),
      .i_wr   (apply_st && (lat_chan == CHW'(g))),
      .i_mode (lat_mode),
      .i_len  (lat_len),
      .o_z    (z_q[g]),
      .o_busy (o_busy[g])
    );

    assign u_I[g].x = Z;
    assign u_I[g].y = y_q;
    assign u_I[g].z = z_q[g];
  end

  assign o_a = {NCHAN{Z}};
  assign o_b = {NCHAN{y_q}};
  assign o_c = z_q;
endmodule

// File: tb/tb_svi_array_sequencer.sv
// Bench for svi_array_sequencer: directed scenarios with literal expectations
// followed by randomized commands, all checked every cycle against a
// behavioural model (per-channel kind / remaining pulse cycles / level).
module tb_svi_array_sequencer;
  localparam int   NCHAN = 6;
  localparam int   WIDTH = 4;
  localparam logic Z     = 1'b0;
  localparam int   CHW   = 3;

  localparam int K_CONST = 0, K_LIT = 1, K_SIG = 2, K_PULSE = 3;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic             i_a = 1'b0;
  logic             i_cmd_valid = 1'b0;
  logic             o_cmd_ready;
  logic [CHW-1:0]   i_cmd_chan = '0;
  logic [1:0]       i_cmd_mode = '0;
  logic [WIDTH-1:0] i_cmd_len = '0;
  logic [NCHAN-1:0] o_a, o_b, o_c, o_busy;

  svi_array_sequencer_if u_I [NCHAN-1:0] ();

  svi_array_sequencer #(.NCHAN(NCHAN), .WIDTH(WIDTH), .Z(Z)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_a         (i_a),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_chan  (i_cmd_chan),
    .i_cmd_mode  (i_cmd_mode),
    .i_cmd_len   (i_cmd_len),
    .u_I         (u_I),
    .o_a         (o_a),
    .o_b         (o_b),
    .o_c         (o_c),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_kind [NCHAN];
  int   m_rem  [NCHAN];
  logic m_z    [NCHAN];
  logic m_y;
  logic m_pend;
  int   m_pch, m_pmd, m_pln;

  always @(posedge i_clk or posedge i_rst) begin : mdl
    int   k [NCHAN];
    int   r [NCHAN];
    logic z [NCHAN];
    if (i_rst) begin
      for (int i = 0; i < NCHAN; i++) begin
        m_kind[i] <= K_CONST;
        m_rem[i]  <= 0;
        m_z[i]    <= Z;
      end
      m_y    <= 1'b0;
      m_pend <= 1'b0;
      m_pch  <= 0;
      m_pmd  <= 0;
      m_pln  <= 0;
    end else begin
      k = m_kind;
      r = m_rem;
      z = m_z;
      // every channel advances one cycle
      for (int i = 0; i < NCHAN; i++) begin
        if (k[i] == K_SIG) z[i] = i_a;
        else if (k[i] == K_PULSE) begin
          r[i] = r[i] - 1;
          if (r[i] == 0) begin
            k[i] = K_CONST;
            z[i] = Z;
          end
        end
      end
      // a pending command overrides whatever that step did
      if (m_pend) begin
        if (m_pch < NCHAN) begin
          r[m_pch] = 0;
          case (m_pmd)
            0: begin k[m_pch] = K_CONST; z[m_pch] = Z;    end
            1: begin k[m_pch] = K_LIT;   z[m_pch] = 1'b1; end
            2: begin k[m_pch] = K_SIG;   z[m_pch] = i_a;  end
            default: begin
              if (m_pln == 0) begin
                k[m_pch] = K_CONST;
                z[m_pch] = Z;
              end else begin
                k[m_pch] = K_PULSE;
                r[m_pch] = m_pln;
                z[m_pch] = 1'b1;
              end
            end
          endcase
        end
        m_pend <= 1'b0;
      end else if (i_cmd_valid) begin
        m_pend <= 1'b1;
        m_pch  <= int'(i_cmd_chan);
        m_pmd  <= int'(i_cmd_mode);
        m_pln  <= int'(i_cmd_len);
      end
      m_kind <= k;
      m_rem  <= r;
      m_z    <= z;
      m_y    <= 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clk) begin : cmp
    logic [NCHAN-1:0] ez, eb;
    for (int i = 0; i < NCHAN; i++) begin
      ez[i] = m_z[i];
      eb[i] = (m_kind[i] == K_PULSE);
    end
    chk("cyc_ready", 64'(o_cmd_ready), 64'(!m_pend));
    chk("cyc_z",     64'(o_c),         64'(ez));
    chk("cyc_busy",  64'(o_busy),      64'(eb));
    chk("cyc_x",     64'(o_a),         64'({NCHAN{Z}}));
    chk("cyc_y",     64'(o_b),         64'({NCHAN{m_y}}));
  end

  // ---------------- stimulus ----------------
  // Returns #1 after the accepting edge.
  task automatic send(input int ch, input int md, input int ln);
    int n = 0;
    i_cmd_valid = 1'b1;
    i_cmd_chan  = CHW'(ch);
    i_cmd_mode  = 2'(md);
    i_cmd_len   = WIDTH'(ln);
    @(negedge i_clk);
    while (!o_cmd_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: ready stayed %0b, required 1", o_cmd_ready);
    end
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    #1 i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_ready", 64'(o_cmd_ready), 64'd1);
    chk("rst_y",     64'(o_b),         64'd0);
    chk("rst_busy",  64'(o_busy),      64'd0);
    chk("rst_z",     64'(o_c),         64'd0);

    // release: y rises one edge later
    @(negedge i_clk);
    i_rst = 1'b0;
    #1 chk("y_before_edge", 64'(o_b), 64'd0);
    @(posedge i_clk);
    #1;
    chk("y_after_edge", 64'(o_b),         64'h3f);
    chk("idle_x",       64'(o_a),         64'd0);
    chk("idle_ready",   64'(o_cmd_ready), 64'd1);

    // PULSE len 5 on channel 3
    send(3, 3, 5);
    chk("apply_ready_low", 64'(o_cmd_ready), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge i_clk);
      #1;
      chk("pulse3_busy",  64'(o_busy[3]),           64'd1);
      chk("pulse3_z",     64'(o_c[3]),              64'd1);
      chk("pulse3_other", 64'(o_busy & 6'b110111),  64'd0);
    end
    @(posedge i_clk);
    #1;
    chk("pulse3_end_busy", 64'(o_busy[3]), 64'd0);
    chk("pulse3_end_z",    64'(o_c[3]),    64'd0);

    // SIGNAL on channel 2
    send(2, 2, 0);
    for (int k = 0; k < 4; k++) begin
      i_a = pat[k];
      @(posedge i_clk);
      #1 chk("signal2", 64'(o_c[2]), 64'(pat[k]));
    end
    i_a = 1'b0;

    // PULSE 15 on channel 0, LIT lands on the expiry edge
    send(0, 3, 15);
    repeat (14) @(posedge i_clk);
    #1;
    send(0, 1, 0);
    chk("collide_busy_pre", 64'(o_busy[0]), 64'd1);
    @(posedge i_clk);
    #1;
    chk("collide_busy", 64'(o_busy[0]), 64'd0);
    chk("collide_z",    64'(o_c[0]),    64'd1);

    // zero-length pulse and out-of-range channel
    send(1, 3, 0);
    @(posedge i_clk);
    #1;
    chk("len0_busy", 64'(o_busy[1]), 64'd0);
    chk("len0_z",    64'(o_c[1]),    64'd0);
    send(7, 1, 0);
    chk("oor_ready", 64'(o_cmd_ready), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("oor_z",    64'(o_c),    64'b000001);
    chk("oor_busy", 64'(o_busy), 64'd0);

    // asynchronous reset in the middle of a pulse on channel 4
    send(4, 3, 10);
    repeat (3) @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("arst_busy",  64'(o_busy),      64'd0);
    chk("arst_z",     64'(o_c),         64'd0);
    chk("arst_y",     64'(o_b),         64'd0);
    chk("arst_ready", 64'(o_cmd_ready), 64'd1);

    // valid held across reset release is taken on the first edge
    i_cmd_valid = 1'b1;
    i_cmd_chan  = 3'd5;
    i_cmd_mode  = 2'd1;
    i_cmd_len   = '0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    chk("held_valid_accept", 64'(o_cmd_ready), 64'd0);
    @(posedge i_clk);
    #1 chk("held_valid_z5", 64'(o_c[5]), 64'd1);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      @(posedge i_clk);
      #1;
      i_a         = 1'($urandom);
      i_cmd_valid = ($urandom_range(0, 2) != 0);
      i_cmd_chan  = CHW'($urandom_range(0, 7));
      i_cmd_mode  = 2'($urandom);
      i_cmd_len   = WIDTH'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        #1 i_rst = 1'b1;
        #1 i_rst = 1'b0;
      end
    end
    i_cmd_valid = 1'b0;
    repeat (20) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
